// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive buffer
package uart_pkg;

  localparam int BYTE_W    = 8;
  localparam int RXF_DEPTH = 16;

  typedef enum logic {
    RXF_IDLE = 1'b0,
    RXF_CLR  = 1'b1
  } rxf_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - circular first-word-fall-through FIFO with count/full/empty
module sync_fifo_fwft
  import uart_pkg::*;
#(
  parameter int DEPTH  = RXF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int WIDTH  = BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  pop_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_en;
  logic              rd_en;

  // Occupancy is tracked explicitly so full and empty never need pointer comparison.
  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - captures UART receiver bytes into a FWFT FIFO with overflow tracking
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = RXF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_rdy_clr,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  input  logic              ovf_clr
);

  rxf_state_e state;
  rxf_state_e state_next;
  logic       capture;
  logic       pop;
  logic       drop;
  logic       empty;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) state <= RXF_IDLE;
    else        state <= state_next;
  end

  // The receiver holds rx_rdy until it sees the clear, so CLR waits for it to drop.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      RXF_IDLE: begin
        if (rx_rdy) begin
          capture    = 1'b1;
          state_next = RXF_CLR;
        end
      end
      RXF_CLR: begin
        if (!rx_rdy) state_next = RXF_IDLE;
      end
      default: state_next = RXF_IDLE;
    endcase
  end

  assign rx_rdy_clr = (state == RXF_CLR);
  assign m_valid    = !empty;
  assign pop        = m_valid && m_ready;
  assign drop       = capture && full && !pop;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  sync_fifo_fwft #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (BYTE_W)
  ) u_fifo (
    .clk       (clk_50m),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (rx_data),
    .pop       (pop),
    .pop_data  (m_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver. It watches the receiver's ready flag and captures each received byte. It acknowledges the receiver with a clear pulse and stores the byte in a circular FIFO. Bytes are presented to the consumer (CPU, LED or protocol logic) through a first-word-fall-through valid/ready interface, so back-to-back serial bytes are not lost while the consumer is busy.

Parameters:
DEPTH, 16, number of byte entries; power of two, at least 2.
ADDR_W, 4, equal to log2(DEPTH); pointer width.

Ports:
clk_50m  input  1  system clock, 50 MHz; all state on the rising edge.
rst_n  input  1  asynchronous active-low reset, deasserted synchronously by the top level.
rx_rdy  input  1  receiver byte-ready flag; level, stays high until cleared.
rx_data  input  8  received byte; valid while rx_rdy is high.
rx_rdy_clr  output  1  ready-clear back to the receiver.
m_data  output  8  head-of-FIFO byte.
m_valid  output  1  high when the FIFO is non-empty.
m_ready  input  1  consumer accepts m_data this cycle.
count  output  ADDR_W+1  number of stored bytes, 0..DEPTH.
full  output  1  count == DEPTH.
overflow  output  1  sticky: a byte was dropped because the FIFO was full.
ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr=0, rd_ptr=0, count=0.
  - State = IDLE; rx_rdy_clr=0, m_valid=0, full=0, overflow=0, m_data=8'h00.
  - Memory contents are don't-care.
- Capture FSM, 2 states:
  - IDLE: if rx_rdy=1 at an edge, the capture event fires and the next state is CLR. Otherwise stay in IDLE.
  - CLR: rx_rdy_clr=1 (Moore output, registered). Go to IDLE at the first edge where rx_rdy=0; otherwise stay in CLR.
  - One receiver byte yields exactly one capture. rx_rdy_clr rises in the cycle after capture.
- Capture event:
  - If (!full || pop): write rx_data to mem[wr_ptr] and increment wr_ptr (wraps modulo DEPTH).
  - Else: drop the byte and set overflow=1. The byte is still acknowledged via CLR.
- Pop: pop = m_valid && m_ready. Increment rd_ptr (wraps modulo DEPTH).
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged (legal at full and at non-empty).
  - Push to empty with no pop: count 0 to 1.
- Read side:
  - FWFT: m_data = mem[rd_ptr] whenever m_valid.
  - m_valid=1 from the edge after the first write.
  - Capture-to-m_valid latency is 1 cycle.
  - m_ready while m_valid=0 is ignored; no pointer change, no underflow.
- Full and empty derive from count, not from pointer equality.
- overflow: set on a dropped byte and cleared by ovf_clr. If both occur in the same cycle, set wins.
- Reset mid-operation: everything returns to reset values and buffered bytes are lost. If rx_rdy is still high after reset, that byte is captured again from IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - the capture state enum (RXF_IDLE, RXF_CLR);
  - the default DEPTH constant;
  - a BYTE_W=8 constant.
- One sub-module, sync_fifo_fwft. It is a parameterised circular buffer with push/pop, count, full and empty.
- uart_rx_fifo instantiates sync_fifo_fwft and adds the capture FSM, rx_rdy_clr and overflow logic.

Test Plan:
- Single byte: rx_rdy high with rx_data=8'hA5, m_ready=0.
  - Expected: rx_rdy_clr high the next cycle; m_valid=1, m_data=8'hA5, count=1.
  - Lower rx_rdy: FSM returns to IDLE. Pulse m_ready: count=0, m_valid=0.
- Ordering with wrap: push 20 bytes 8'h00..8'h13, popping 4 after the first 12.
  - Expected: pops return 8'h00..8'h13 in order; pointers wrap with no loss; count never exceeds 16.
- Overflow: 17 captures with m_ready=0.
  - Expected: full=1 after the 16th capture. The 17th byte (8'h10) is dropped, overflow=1, and rx_rdy_clr is still asserted.
  - Then pop: first byte is 8'h00. ovf_clr clears overflow.
- Simultaneous push/pop at full: FIFO full, m_ready=1 in the capture cycle.
  - Expected: byte accepted, count stays 16, overflow stays 0, head advances.
- Held rx_rdy: rx_rdy kept high 10 cycles for one byte.
  - Expected: exactly one write (count=1); rx_rdy_clr high for all CLR cycles; IDLE only after rx_rdy falls.
- Async reset mid-stream: assert rst_n=0 with count=5, in state CLR, away from a clock edge.
  - Expected: outputs go to reset values immediately (count=0, m_valid=0, rx_rdy_clr=0, overflow=0).
